clause_scanner: RTL and testbench
=================================

# clause_scanner

Clause-evaluation stage directly downstream of `clausedb` in the hardware BCP path. On `start` it latches the current variable assignment and reads clauses 0..`num_clauses`-1 from `clausedb` in order. Each clause is classified as satisfied, unit or conflicting. Unit clauses are streamed out as implications over a valid/ready handshake, and the first conflict ends the scan.

## Interface
- `address_width`, 8, clausedb address width.
- `data_width`, 8, clausedb word width; must be even. `NV = data_width/2` variables. `VW = max(1, clog2(NV))`.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  scan request; sampled only when idle.
- `num_clauses`  in  address_width+1  clauses to scan; sampled with `start`.
- `assign_valid`  in  NV  bit i=1: variable i assigned; sampled with `start`.
- `assign_val`  in  NV  value of variable i when assigned; sampled with `start`.
- `db_en`  out  1  clausedb enable.
- `db_r_w`  out  1  clausedb read/write; 1=read. Constant 1 out of reset.
- `db_address`  out  address_width  clausedb address.
- `db_dout`  in  data_width  clausedb read data.
- `imply_valid`  out  1  implication available.
- `imply_ready`  in  1  consumer accepts implication.
- `imply_var`  out  VW  implied variable index.
- `imply_val`  out  1  implied value.
- `imply_addr`  out  address_width  address of the unit clause.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at end of scan.
- `conflict`  out  1  scan ended on a conflict; valid from `done` until next `start`.
- `conflict_addr`  out  address_width  address of the conflicting clause.
- `unit_count`  out  address_width+1  implications accepted in the last scan.

## Operation
- Clause word encoding: variable i occupies bits [2i+1:2i]. Bit 2i+1 = positive literal, bit 2i = negative literal.
- Per-variable literal status, against the assignment latched at `start`:
  - True: assigned with matching polarity.
  - False: assigned with opposite polarity.
  - Free: unassigned.
  - Variable with both bits set: clause is satisfied (tautology).
- Classification, in priority order:
  - Word = 0: skipped (deleted clause), no effect.
  - Any true literal or tautology: satisfied.
  - Zero free literals: conflict.
  - Exactly one free literal: unit. Implication is that variable with the literal's polarity; positive gives value 1.
  - Two or more free literals: unresolved, no effect.
- FSM states IDLE, FETCH, EVAL, EMIT, DONE.
  - IDLE: `start`=1 latches inputs and clears `conflict` and `unit_count`. `num_clauses`=0 goes to DONE; otherwise FETCH with address 0.
  - FETCH: `db_en`=1, `db_address`=current address. Next state EVAL.
  - EVAL: classify `db_dout`.
    - Conflict: record `conflict_addr`, set `conflict`, go to DONE.
    - Unit: go to EMIT.
    - Last clause otherwise: go to DONE.
    - Else: increment address and go to FETCH.
  - EMIT: `imply_valid`=1 with fields stable until `imply_ready`=1. On acceptance, increment `unit_count`, then continue as EVAL's non-unit exit.
  - DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored.
- `db_en`=0 outside FETCH; `db_r_w` is always 1. The block never writes.
- `num_clauses` > 2^address_width is clamped to 2^address_width. Address does not wrap.

## Timing
- Reset values: `db_en`=0, `db_r_w`=1, `db_address`=0, `imply_valid`=0, `imply_var`=0, `imply_val`=0, `imply_addr`=0, `busy`=0, `done`=0, `conflict`=0, `conflict_addr`=0, `unit_count`=0. FSM goes to IDLE.
- Reset mid-scan aborts immediately: no `done` pulse, pending implication dropped.
- clausedb read latency is one cycle. The address driven in FETCH (cycle k) is registered at the edge ending cycle k, and `db_dout` is valid during EVAL (cycle k+1).
- Cycle 0 is the cycle in which `start` is sampled.
  - Clause j: FETCH in cycle 2j+1, EVAL in cycle 2j+2.
  - N clauses with no units: `done` in cycle 2N+1.
  - `num_clauses`=0: `done` in cycle 1 and no `db_en`.
- Each unit clause adds one EMIT cycle per cycle of `imply_valid`. With `imply_ready` held at 1 it adds exactly one cycle.
- Conflict in EVAL of clause j: `done` in cycle 2j+3; no further `db_en`.
- `conflict`, `conflict_addr` and `unit_count` hold from `done` until the next accepted `start`.

## Test plan
- Empty scan: `num_clauses`=0, `start` → `done` in cycle 1, `db_en` never high, `conflict`=0, `unit_count`=0.
- Unit clause: mem[0]=8'b0000_0110; var0 assigned 0, var1 free; `imply_ready`=1.
  - Required: `imply_valid` for one cycle with `imply_var`=1, `imply_val`=0, `imply_addr`=0.
  - Then `done` with `conflict`=0 and `unit_count`=1.
- Conflict stops scan: mem[0]=8'b0000_0010, mem[1]=8'b0000_0001, mem[2]=8'b0000_1000; var0 assigned 1; `num_clauses`=3.
  - Required: `done` in cycle 5, `conflict`=1, `conflict_addr`=1.
  - `db_address`=2 never driven with `db_en`=1.
- Backpressure: test 2 with `imply_ready` low for 3 cycles.
  - Required: `imply_valid` held with identical fields for 4 cycles and no `db_en` meanwhile.
  - `done` 3 cycles later than in test 2.
- Skip/tautology: mem[0]=8'h00, mem[1]=8'b0000_0011; all variables free; `num_clauses`=2.
  - Required: no implication, `conflict`=0, `done` in cycle 5.
- Reset and ignored start:
  - `reset`=1 during an EVAL cycle → the next cycle has all outputs at reset values; no `done` follows.
  - `start` pulsed while busy → no effect on the scan in progress.

Source files
------------

// File: rtl/clause_scanner_if.sv
// Port bundle for clause_scanner: scan control, clausedb read bus, implication stream, status.
// No logic, so no latency.
// Backpressure is carried by imply_valid/imply_ready; the clausedb bus has none.
interface clause_scanner_if #(
    parameter int address_width = 8,
    parameter int data_width    = 8
);
    localparam int NV = data_width / 2;
    localparam int VW = (NV > 1) ? $clog2(NV) : 1;

    logic                     start;
    logic [address_width:0]   num_clauses;
    logic [NV-1:0]            assign_valid;
    logic [NV-1:0]            assign_val;
    logic                     db_en;
    logic                     db_r_w;
    logic [address_width-1:0] db_address;
    logic [data_width-1:0]    db_dout;
    logic                     imply_valid;
    logic                     imply_ready;
    logic [VW-1:0]            imply_var;
    logic                     imply_val;
    logic [address_width-1:0] imply_addr;
    logic                     busy;
    logic                     done;
    logic                     conflict;
    logic [address_width-1:0] conflict_addr;
    logic [address_width:0]   unit_count;

    // Scanner side
    modport master (
        input  start, num_clauses, assign_valid, assign_val, db_dout, imply_ready,
        output db_en, db_r_w, db_address, imply_valid, imply_var, imply_val, imply_addr,
               busy, done, conflict, conflict_addr, unit_count
    );

    // Requester / clausedb / implication consumer side
    modport slave (
        output start, num_clauses, assign_valid, assign_val, db_dout, imply_ready,
        input  db_en, db_r_w, db_address, imply_valid, imply_var, imply_val, imply_addr,
               busy, done, conflict, conflict_addr, unit_count
    );
endinterface

// File: rtl/clause_scanner.sv
// Scans clauses 0..N-1 from clausedb, classifies each against a latched assignment, streams unit implications.
// Latency: 2 cycles per clause (FETCH+EVAL), +1 per EMIT cycle; done 1 cycle after the last EVAL.
// Backpressure: EMIT holds implication fields stable and stalls the scan until imply_ready.
module clause_scanner #(
    parameter int address_width = 8,
    parameter int data_width    = 8
) (
    input logic                clock,
    input logic                reset,
    clause_scanner_if.master   sif
);
    localparam int NV = data_width / 2;
    localparam int VW = (NV > 1) ? $clog2(NV) : 1;
    localparam int AW = address_width;
    localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_EMIT, S_DONE} state_t;

    state_t         state_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  last_q;
    logic [AW-1:0]  last_d;
    logic [NV-1:0]  asg_vld_q;
    logic [NV-1:0]  asg_val_q;
    logic           db_en_q;
    logic [AW-1:0]  db_address_q;
    logic           imply_valid_q;
    logic [VW-1:0]  imply_var_q;
    logic           imply_val_q;
    logic [AW-1:0]  imply_addr_q;
    logic           busy_q;
    logic           done_q;
    logic           conflict_q;
    logic [AW-1:0]  conflict_addr_q;
    logic [AW:0]    unit_count_q;

    logic           word_zero;
    logic           any_sat;
    logic           free_one;
    logic           free_many;
    logic [VW-1:0]  free_var;
    logic           free_pol;
    logic           at_last;

    assign sif.db_en         = db_en_q;
    assign sif.db_r_w        = 1'b1;
    assign sif.db_address    = db_address_q;
    assign sif.imply_valid   = imply_valid_q;
    assign sif.imply_var     = imply_var_q;
    assign sif.imply_val     = imply_val_q;
    assign sif.imply_addr    = imply_addr_q;
    assign sif.busy          = busy_q;
    assign sif.done          = done_q;
    assign sif.conflict      = conflict_q;
    assign sif.conflict_addr = conflict_addr_q;
    assign sif.unit_count    = unit_count_q;

    assign at_last = (addr_q == last_q);

    // Index of the final clause; counts beyond the address space clamp to the top address
    always_comb begin
        last_d = '1;
        if (sif.num_clauses <= MAX_N) begin
            last_d = AW'(sif.num_clauses - (AW + 1)'(1));
        end
    end

    // Classify the clause word: tautology or matching literal satisfies; otherwise count free literals
    always_comb begin
        word_zero = (sif.db_dout == '0);
        any_sat   = 1'b0;
        free_one  = 1'b0;
        free_many = 1'b0;
        free_var  = '0;
        free_pol  = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (sif.db_dout[2*i+1] && sif.db_dout[2*i]) begin
                any_sat = 1'b1;
            end else if (sif.db_dout[2*i+1] || sif.db_dout[2*i]) begin
                if (asg_vld_q[i]) begin
                    // Positive literal is true when the variable is 1, negative when it is 0
                    if (sif.db_dout[2*i+1] == asg_val_q[i]) any_sat = 1'b1;
                end else begin
                    if (free_one) free_many = 1'b1;
                    free_one = 1'b1;
                    free_var = VW'(i);
                    free_pol = sif.db_dout[2*i+1];
                end
            end
        end
    end

    // Scan FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            last_q          <= '0;
            asg_vld_q       <= '0;
            asg_val_q       <= '0;
            db_en_q         <= 1'b0;
            db_address_q    <= '0;
            imply_valid_q   <= 1'b0;
            imply_var_q     <= '0;
            imply_val_q     <= 1'b0;
            imply_addr_q    <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            conflict_q      <= 1'b0;
            conflict_addr_q <= '0;
            unit_count_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sif.start) begin
                        asg_vld_q    <= sif.assign_valid;
                        asg_val_q    <= sif.assign_val;
                        last_q       <= last_d;
                        conflict_q   <= 1'b0;
                        unit_count_q <= '0;
                        addr_q       <= '0;
                        db_address_q <= '0;
                        busy_q       <= 1'b1;
                        if (sif.num_clauses == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            db_en_q <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Address was presented this cycle; data arrives next cycle
                    db_en_q <= 1'b0;
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    if (!word_zero && !any_sat && !free_one) begin
                        conflict_q      <= 1'b1;
                        conflict_addr_q <= addr_q;
                        done_q          <= 1'b1;
                        state_q         <= S_DONE;
                    end else if (!word_zero && !any_sat && !free_many) begin
                        imply_valid_q <= 1'b1;
                        imply_var_q   <= free_var;
                        imply_val_q   <= free_pol;
                        imply_addr_q  <= addr_q;
                        state_q       <= S_EMIT;
                    end else if (at_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q       <= addr_q + 1'b1;
                        db_address_q <= addr_q + 1'b1;
                        db_en_q      <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    if (sif.imply_ready) begin
                        imply_valid_q <= 1'b0;
                        unit_count_q  <= unit_count_q + 1'b1;
                        if (at_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q       <= addr_q + 1'b1;
                            db_address_q <= addr_q + 1'b1;
                            db_en_q      <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_scanner.sv
// Directed bench for clause_scanner with a one-cycle-latency clausedb model.
// Cycle k of a scan is observed at the falling edge k cycles after start is applied.
// The implication consumer withholds imply_ready for a programmable number of valid cycles.
module tb_clause_scanner;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] mem [256];

    clause_scanner_if #(.address_width(8), .data_width(8)) sif ();

    clause_scanner #(.address_width(8), .data_width(8)) dut (
        .clock (clock),
        .reset (reset),
        .sif   (sif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // clausedb: address registered with enable, data visible the following cycle
    always @(posedge clock) begin
        if (sif.db_en) sif.db_dout <= mem[sif.db_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_scan(
        input  logic [8:0] num, input logic [3:0] vld, input logic [3:0] val,
        input  int hold, input int restart_at, input int max_cyc,
        output int done_cyc, output int en_cnt, output bit en_addr2, output int vcnt,
        output logic [1:0] v_var, output logic v_val, output logic [7:0] v_addr,
        output bit unstable, output bit en_in_emit
    );
        done_cyc = -1; en_cnt = 0; en_addr2 = 0; vcnt = 0;
        v_var = '0; v_val = 1'b0; v_addr = '0; unstable = 0; en_in_emit = 0;
        sif.num_clauses  = num;
        sif.assign_valid = vld;
        sif.assign_val   = val;
        sif.imply_ready  = (hold == 0);
        sif.start        = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clock);
            sif.start = (k == restart_at);
            if (k == restart_at) sif.num_clauses = '0;
            if (sif.db_en) begin
                en_cnt++;
                if (sif.db_address == 8'd2) en_addr2 = 1;
            end
            if (sif.imply_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    v_var = sif.imply_var; v_val = sif.imply_val; v_addr = sif.imply_addr;
                end else if (sif.imply_var !== v_var || sif.imply_val !== v_val ||
                             sif.imply_addr !== v_addr) begin
                    unstable = 1;
                end
                if (sif.db_en) en_in_emit = 1;
                sif.imply_ready = (vcnt > hold);
            end
            if (sif.done) begin
                done_cyc = k;
                break;
            end
        end
        sif.start = 1'b0;
        sif.imply_ready = 1'b1;
    endtask

    initial begin
        int done_cyc, en_cnt, vcnt, done_seen;
        bit en_addr2, unstable, en_in_emit;
        logic [1:0] v_var;
        logic v_val;
        logic [7:0] v_addr;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        sif.start = 1'b0; sif.num_clauses = '0; sif.assign_valid = '0; sif.assign_val = '0;
        sif.imply_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        chk("rst_db_en", 32'(sif.db_en), 0);
        chk("rst_db_r_w", 32'(sif.db_r_w), 1);
        chk("rst_db_address", 32'(sif.db_address), 0);
        chk("rst_imply_valid", 32'(sif.imply_valid), 0);
        chk("rst_imply_fields", {21'd0, sif.imply_var, sif.imply_val, sif.imply_addr}, 0);
        chk("rst_busy", 32'(sif.busy), 0);
        chk("rst_done", 32'(sif.done), 0);
        chk("rst_conflict", 32'(sif.conflict), 0);
        chk("rst_conflict_addr", 32'(sif.conflict_addr), 0);
        chk("rst_unit_count", 32'(sif.unit_count), 0);
        @(negedge clock);

        // Empty scan
        run_scan(9'd0, 4'b0000, 4'b0000, 0, 0, 20, done_cyc, en_cnt, en_addr2, vcnt,
                 v_var, v_val, v_addr, unstable, en_in_emit);
        chk("empty_done_cycle", 32'(done_cyc), 1);
        chk("empty_db_en_count", 32'(en_cnt), 0);
        chk("empty_conflict", 32'(sif.conflict), 0);
        chk("empty_unit_count", 32'(sif.unit_count), 0);
        @(negedge clock);
        chk("empty_done_pulse", 32'(sif.done), 0);
        chk("empty_busy_after", 32'(sif.busy), 0);

        // Conflict stops scan: clause 0 satisfied, clause 1 conflicts, clause 2 never fetched
        mem[0] = 8'b0000_0010; mem[1] = 8'b0000_0001; mem[2] = 8'b0000_1000;
        run_scan(9'd3, 4'b0001, 4'b0001, 0, 0, 40, done_cyc, en_cnt, en_addr2, vcnt,
                 v_var, v_val, v_addr, unstable, en_in_emit);
        chk("conf_done_cycle", 32'(done_cyc), 5);
        chk("conf_conflict", 32'(sif.conflict), 1);
        chk("conf_conflict_addr", 32'(sif.conflict_addr), 1);
        chk("conf_addr2_fetched", 32'(en_addr2), 0);
        chk("conf_db_en_count", 32'(en_cnt), 2);
        chk("conf_no_implication", 32'(vcnt), 0);
        @(negedge clock);
        chk("conf_hold_after_done", 32'(sif.conflict), 1);

        // Unit clause: var1 negative literal is the only free one
        mem[0] = 8'b0000_0110; mem[1] = 8'h00; mem[2] = 8'h00;
        run_scan(9'd1, 4'b0001, 4'b0000, 0, 0, 40, done_cyc, en_cnt, en_addr2, vcnt,
                 v_var, v_val, v_addr, unstable, en_in_emit);
        chk("unit_valid_cycles", 32'(vcnt), 1);
        chk("unit_var", 32'(v_var), 1);
        chk("unit_val", 32'(v_val), 0);
        chk("unit_addr", 32'(v_addr), 0);
        chk("unit_done_cycle", 32'(done_cyc), 4);
        chk("unit_conflict_cleared", 32'(sif.conflict), 0);
        chk("unit_count", 32'(sif.unit_count), 1);
        @(negedge clock);

        // Backpressure: imply_ready low for the first 3 valid cycles
        run_scan(9'd1, 4'b0001, 4'b0000, 3, 0, 40, done_cyc, en_cnt, en_addr2, vcnt,
                 v_var, v_val, v_addr, unstable, en_in_emit);
        chk("bp_valid_cycles", 32'(vcnt), 4);
        chk("bp_fields_stable", 32'(unstable), 0);
        chk("bp_var", 32'(v_var), 1);
        chk("bp_no_db_en_in_emit", 32'(en_in_emit), 0);
        chk("bp_done_cycle", 32'(done_cyc), 7);
        chk("bp_unit_count", 32'(sif.unit_count), 1);
        @(negedge clock);

        // Skip and tautology, with start (num_clauses=0) pulsed while busy in cycle 2
        mem[0] = 8'h00; mem[1] = 8'b0000_0011;
        run_scan(9'd2, 4'b0000, 4'b0000, 0, 2, 40, done_cyc, en_cnt, en_addr2, vcnt,
                 v_var, v_val, v_addr, unstable, en_in_emit);
        chk("skip_done_cycle", 32'(done_cyc), 5);
        chk("skip_no_implication", 32'(vcnt), 0);
        chk("skip_conflict", 32'(sif.conflict), 0);
        chk("skip_db_en_count", 32'(en_cnt), 2);
        chk("skip_unit_count", 32'(sif.unit_count), 0);
        @(negedge clock);

        // Reset during EVAL of clause 0 (unresolved clause, 3 clauses requested)
        mem[0] = 8'b0000_1010;
        sif.num_clauses = 9'd3; sif.assign_valid = '0; sif.assign_val = '0;
        sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        @(negedge clock);
        chk("rstmid_busy_in_eval", 32'(sif.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstmid_busy", 32'(sif.busy), 0);
        chk("rstmid_db_en", 32'(sif.db_en), 0);
        chk("rstmid_imply_var", 32'(sif.imply_var), 0);
        chk("rstmid_imply_valid", 32'(sif.imply_valid), 0);
        chk("rstmid_db_address", 32'(sif.db_address), 0);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (sif.done || sif.db_en) done_seen++;
        end
        chk("rstmid_no_done_or_fetch", 32'(done_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
